// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: baud-rate controller and tick scheduler for the UART_BCD datapath.
// It samples the enable/baud-select switches and applies a new rate only while TX and RX
// are both idle. A single divide counter produces a full-bit tick and a half-bit tick.
// rx_start re-centres the counter on a detected start edge.
module uart_baud_ctrl #(
  parameter int DIV_9600   = 5208,
  parameter int DIV_57600  = 868,
  parameter int DIV_115200 = 434,
  parameter int CNT_W      = 13
) (
  input  logic       src_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] baud_sel,
  input  logic       tx_busy,
  input  logic       rx_busy,
  input  logic       rx_start,
  output logic       uart_en,
  output logic       baud_tick,
  output logic       half_tick,
  output logic [1:0] active_sel,
  output logic       sel_invalid
);

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    WAIT_IDLE = 2'd1,
    RUN       = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [1:0]       pend_sel_q, pend_sel_d;
  logic [1:0]       active_sel_q, active_sel_d;
  logic             uart_en_q, uart_en_d;
  logic             baud_tick_q, baud_tick_d;
  logic             half_tick_q, half_tick_d;
  logic             sel_invalid_q, sel_invalid_d;
  logic             idle;

  // Divisor (cycles per bit) for a baud select code; code 11 never reaches this.
  function automatic logic [CNT_W-1:0] div_for(input logic [1:0] sel);
    case (sel)
      2'b01:   div_for = CNT_W'(DIV_57600);
      2'b10:   div_for = CNT_W'(DIV_115200);
      default: div_for = CNT_W'(DIV_9600);
    endcase
  endfunction

  assign idle = !tx_busy && !rx_busy;

  // Next-state, counter and tick generation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    pend_sel_d    = pend_sel_q;
    active_sel_d  = active_sel_q;
    uart_en_d     = uart_en_q;
    baud_tick_d   = 1'b0;
    half_tick_d   = 1'b0;
    sel_invalid_d = 1'b0;
    case (state_q)
      DISABLED: begin
        cnt_d        = '0;
        uart_en_d    = 1'b0;
        active_sel_d = 2'b11;
        if (enable) begin
          if (baud_sel == 2'b11) begin
            sel_invalid_d = 1'b1;
          end else begin
            pend_sel_d = baud_sel;
            state_d    = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (!enable) begin
          state_d = DISABLED;
        end else if (idle) begin
          div_d        = div_for(pend_sel_q);
          cnt_d        = '0;
          active_sel_d = pend_sel_q;
          uart_en_d    = 1'b1;
          state_d      = RUN;
        end
      end
      RUN, DRAIN: begin
        // rx_start restarts the bit period and swallows any tick due this cycle.
        if (rx_start) begin
          cnt_d = '0;
        end else if (cnt_q >= div_q - CNT_W'(1)) begin
          cnt_d       = '0;
          baud_tick_d = 1'b1;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          half_tick_d = (cnt_q == (div_q >> 1) - CNT_W'(1));
        end
        if (state_q == RUN) begin
          if (!enable) state_d = DRAIN;
        end else if (idle) begin
          // Drain complete: stop everything on this edge; enable is re-evaluated in DISABLED.
          state_d      = DISABLED;
          cnt_d        = '0;
          uart_en_d    = 1'b0;
          baud_tick_d  = 1'b0;
          half_tick_d  = 1'b0;
          active_sel_d = 2'b11;
        end
      end
      default: state_d = DISABLED;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge src_clk) begin
    if (!rst_n) begin
      state_q       <= DISABLED;
      cnt_q         <= '0;
      div_q         <= CNT_W'(DIV_9600);
      pend_sel_q    <= 2'b00;
      active_sel_q  <= 2'b11;
      uart_en_q     <= 1'b0;
      baud_tick_q   <= 1'b0;
      half_tick_q   <= 1'b0;
      sel_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      pend_sel_q    <= pend_sel_d;
      active_sel_q  <= active_sel_d;
      uart_en_q     <= uart_en_d;
      baud_tick_q   <= baud_tick_d;
      half_tick_q   <= half_tick_d;
      sel_invalid_q <= sel_invalid_d;
    end
  end

  assign uart_en     = uart_en_q;
  assign baud_tick   = baud_tick_q;
  assign half_tick   = half_tick_q;
  assign active_sel  = active_sel_q;
  assign sel_invalid = sel_invalid_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed testbench for uart_baud_ctrl: rates, invalid select, drain, rx_start resync, reset.
module tb_uart_baud_ctrl;

  logic       src_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] baud_sel = 2'b00;
  logic       tx_busy = 1'b0;
  logic       rx_busy = 1'b0;
  logic       rx_start = 1'b0;
  logic       uart_en;
  logic       baud_tick;
  logic       half_tick;
  logic [1:0] active_sel;
  logic       sel_invalid;

  int n_assert = 0;
  int n_fail = 0;

  uart_baud_ctrl dut (
    .src_clk    (src_clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .baud_sel   (baud_sel),
    .tx_busy    (tx_busy),
    .rx_busy    (rx_busy),
    .rx_start   (rx_start),
    .uart_en    (uart_en),
    .baud_tick  (baud_tick),
    .half_tick  (half_tick),
    .active_sel (active_sel),
    .sel_invalid(sel_invalid)
  );

  always #10 src_clk = ~src_clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge src_clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until the chosen tick (0 = baud, 1 = half) is seen; n = cycles taken (budget on timeout).
  task automatic count_until(input int which, input int budget, output int n);
    logic hit;
    n = 0;
    do begin
      step();
      n++;
      hit = (which == 0) ? baud_tick : half_tick;
    end while (!hit && n < budget);
  endtask

  task automatic disable_uart();
    enable = 1'b0;
    repeat (3) step();
    check("disable uart_en", uart_en, 0);
    check("disable active_sel", active_sel, 3);
  endtask

  // Enable at a rate, then measure half offset, first tick and one full period.
  task automatic run_rate(input logic [1:0] sel, input int div, input string tag);
    int n;
    baud_sel = sel;
    enable = 1'b1;
    step();
    step();
    check({tag, " uart_en"}, uart_en, 1);
    check({tag, " active_sel"}, active_sel, int'(sel));
    count_until(1, 2 * div, n);
    check({tag, " half offset"}, n, div / 2);
    count_until(0, 2 * div, n);
    check({tag, " first tick rest"}, n, div - div / 2);
    count_until(0, 2 * div, n);
    check({tag, " period"}, n, div);
  endtask

  initial begin
    int n;
    int nt;
    int bad;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    check("rst uart_en", uart_en, 0);
    check("rst baud_tick", baud_tick, 0);
    check("rst half_tick", half_tick, 0);
    check("rst sel_invalid", sel_invalid, 0);
    check("rst active_sel", active_sel, 3);

    // 9600: 2-cycle enable latency, then timing; baud_sel change while running is ignored
    rst_n = 1'b1;
    baud_sel = 2'b00;
    enable = 1'b1;
    step();
    check("9600 uart_en after 1", uart_en, 0);
    step();
    check("9600 uart_en after 2", uart_en, 1);
    check("9600 active_sel", active_sel, 0);
    count_until(1, 10000, n);
    check("9600 half offset", n, 2604);
    count_until(0, 10000, n);
    check("9600 first tick rest", n, 2604);
    baud_sel = 2'b10;
    count_until(0, 10000, n);
    check("9600 period after sel change", n, 5208);
    step();
    check("9600 tick one cycle", baud_tick, 0);
    check("9600 active_sel kept", active_sel, 0);
    disable_uart();

    // 57600 and 115200
    run_rate(2'b01, 868, "57600");
    disable_uart();
    run_rate(2'b10, 434, "115200");
    disable_uart();

    // Invalid select while disabled
    baud_sel = 2'b11;
    enable = 1'b1;
    step();
    step();
    check("inv sel_invalid", sel_invalid, 1);
    check("inv active_sel", active_sel, 3);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (uart_en || baud_tick || half_tick) bad++;
    end
    check("inv no activity", bad, 0);
    enable = 1'b0;
    step();
    check("inv sel_invalid clears", sel_invalid, 0);

    // Drain at 115200: tx_busy holds the UART running for 1000 cycles
    baud_sel = 2'b10;
    enable = 1'b1;
    step();
    step();
    check("drain uart_en up", uart_en, 1);
    tx_busy = 1'b1;
    enable = 1'b0;
    nt = 0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (baud_tick) nt++;
      if (!uart_en) bad++;
    end
    check("drain tick count", nt, 2);
    check("drain uart_en held", bad, 0);
    tx_busy = 1'b0;
    step();
    check("drain uart_en falls", uart_en, 0);
    check("drain active_sel", active_sel, 3);
    repeat (2) step();

    // rx_start resync at counter = 300
    baud_sel = 2'b10;
    enable = 1'b1;
    step();
    step();
    check("rx uart_en", uart_en, 1);
    repeat (300) step();
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    check("rx no baud that cycle", baud_tick, 0);
    check("rx no half that cycle", half_tick, 0);
    count_until(1, 1000, n);
    check("rx half after resync", n, 217);
    count_until(0, 1000, n);
    check("rx baud after resync", n, 217);

    // rx_start in the wrap cycle suppresses the tick
    repeat (433) step();
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    check("rx wrap no baud", baud_tick, 0);
    count_until(0, 1000, n);
    check("rx wrap next baud", n, 434);

    // Reset mid-run
    repeat (50) step();
    rst_n = 1'b0;
    enable = 1'b0;
    step();
    check("midrst uart_en", uart_en, 0);
    check("midrst baud_tick", baud_tick, 0);
    check("midrst half_tick", half_tick, 0);
    check("midrst sel_invalid", sel_invalid, 0);
    check("midrst active_sel", active_sel, 3);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
